// File: rtl/data_sram_ctrl_if.sv
// Data SRAM bus between the MEM-stage controller (master) and the memory
// system (slave).
//
// Handshake: the master raises data_req_o with data_wr_o/size/wstrb/addr/wdata
// and holds every field stable until the slave answers data_addr_ok_i. The
// request drops in the cycle after addr_ok. data_data_ok_i (with data_rdata_i
// for reads) arrives in the addr_ok cycle or any later cycle. Exactly one
// data_ok is returned per accepted request.
interface data_sram_ctrl_if;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_wr_o, data_size_o, data_wstrb_o,
               data_addr_o, data_wdata_o,
        input  data_addr_ok_i, data_data_ok_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_wr_o, data_size_o, data_wstrb_o,
               data_addr_o, data_wdata_o,
        output data_addr_ok_i, data_data_ok_i, data_rdata_i
    );
endinterface

// File: rtl/data_sram_ctrl.sv
// MEM-stage data SRAM controller: turns a load/store into one bus transaction,
// stalls the pipeline while it is outstanding, and captures the raw read word
// for the WB-stage load aligner. A flushed transaction is still completed on
// the bus (never retracted) but its result is dropped.
module data_sram_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_i,
    input  logic        mem_wen_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    input  logic        pipe_stall_i,
    data_sram_ctrl_if.master bus,
    output logic [31:0] mem_rdata_o,
    output logic        mem_stall_o,
    output logic [1:0]  dbg_state_o   // 0 IDLE, 1 REQ, 2 WAIT, 3 DONE
);
    // Opcode encodings, identical to the ALUOP_* values of defines.vh.
    localparam logic [7:0] ALUOP_LB  = 8'he0;
    localparam logic [7:0] ALUOP_LH  = 8'he1;
    localparam logic [7:0] ALUOP_LWL = 8'he2;
    localparam logic [7:0] ALUOP_LW  = 8'he3;
    localparam logic [7:0] ALUOP_LBU = 8'he4;
    localparam logic [7:0] ALUOP_LHU = 8'he5;
    localparam logic [7:0] ALUOP_LWR = 8'he6;
    localparam logic [7:0] ALUOP_SB  = 8'he8;
    localparam logic [7:0] ALUOP_SH  = 8'he9;
    localparam logic [7:0] ALUOP_SWL = 8'hea;
    localparam logic [7:0] ALUOP_SW  = 8'heb;
    localparam logic [7:0] ALUOP_SWR = 8'hee;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    logic        drop;
    logic [1:0]  byte_off;
    logic [31:0] word_addr;
    logic [4:0]  swl_shamt;
    logic [4:0]  swr_shamt;
    logic [1:0]  n_size;
    logic [31:0] n_addr;
    logic [3:0]  n_wstrb;
    logic [31:0] n_wdata;
    logic        busy;

    assign byte_off  = mem_addr_i[1:0];
    assign word_addr = {mem_addr_i[31:2], 2'b00};
    assign swl_shamt = {2'd3 - byte_off, 3'b000};
    assign swr_shamt = {byte_off, 3'b000};

    // Bus fields for the instruction currently in MEM; registered at issue.
    always_comb begin
        n_size  = 2'd2;
        n_addr  = mem_addr_i;
        n_wstrb = 4'b0000;
        n_wdata = 32'd0;
        case (aluop_i)
            ALUOP_LB, ALUOP_LBU: n_size = 2'd0;
            ALUOP_LH, ALUOP_LHU: n_size = 2'd1;
            ALUOP_LW:            n_size = 2'd2;
            ALUOP_LWL, ALUOP_LWR: n_addr = word_addr;
            ALUOP_SB: begin
                n_size  = 2'd0;
                n_wstrb = 4'b0001 << byte_off;
                n_wdata = {4{mem_wdata_i[7:0]}};
            end
            ALUOP_SH: begin
                n_size  = 2'd1;
                n_wstrb = byte_off[1] ? 4'b1100 : 4'b0011;
                n_wdata = {2{mem_wdata_i[15:0]}};
            end
            ALUOP_SW: begin
                n_wstrb = 4'b1111;
                n_wdata = mem_wdata_i;
            end
            ALUOP_SWL: begin
                n_addr = word_addr;
                case (byte_off)
                    2'd0:    n_wstrb = 4'b0001;
                    2'd1:    n_wstrb = 4'b0011;
                    2'd2:    n_wstrb = 4'b0111;
                    default: n_wstrb = 4'b1111;
                endcase
                n_wdata = mem_wdata_i >> swl_shamt;
            end
            ALUOP_SWR: begin
                n_addr = word_addr;
                case (byte_off)
                    2'd0:    n_wstrb = 4'b1111;
                    2'd1:    n_wstrb = 4'b1110;
                    2'd2:    n_wstrb = 4'b1100;
                    default: n_wstrb = 4'b1000;
                endcase
                n_wdata = mem_wdata_i << swr_shamt;
            end
            default: ;
        endcase
    end

    // Transaction FSM with registered bus outputs and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            drop             <= 1'b0;
            bus.data_req_o   <= 1'b0;
            bus.data_wr_o    <= 1'b0;
            bus.data_size_o  <= 2'd0;
            bus.data_wstrb_o <= 4'd0;
            bus.data_addr_o  <= 32'd0;
            bus.data_wdata_o <= 32'd0;
            mem_rdata_o      <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_en_i && !flush_i) begin
                        state            <= S_REQ;
                        bus.data_req_o   <= 1'b1;
                        bus.data_wr_o    <= mem_wen_i;
                        bus.data_size_o  <= n_size;
                        bus.data_wstrb_o <= n_wstrb;
                        bus.data_addr_o  <= n_addr;
                        bus.data_wdata_o <= n_wdata;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (flush_i) drop <= 1'b1;
                    if (state == S_REQ && bus.data_addr_ok_i) begin
                        bus.data_req_o <= 1'b0;
                        if (!bus.data_data_ok_i) state <= S_WAIT;
                    end
                    // Completion: a result flushed now or earlier is discarded.
                    if (bus.data_data_ok_i && (state == S_WAIT || bus.data_addr_ok_i)) begin
                        if (drop || flush_i) begin
                            state <= S_IDLE;
                            drop  <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            if (!bus.data_wr_o) mem_rdata_o <= bus.data_rdata_i;
                        end
                    end
                end
                S_DONE: begin
                    if (flush_i || !pipe_stall_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stall while issuing or outstanding; a dropped transaction only stalls a
    // newer instruction that itself needs the bus.
    assign busy        = (state == S_REQ) || (state == S_WAIT);
    assign mem_stall_o = !rst && (((state == S_IDLE) && mem_en_i && !flush_i) ||
                                  (busy && (!drop || mem_en_i)));
    assign dbg_state_o = state;
endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: directed scenarios followed by randomized
// transactions, each checked cycle by cycle against a timeline model.
module tb_data_sram_ctrl;
    localparam logic [7:0] ALUOP_LB  = 8'he0;
    localparam logic [7:0] ALUOP_LH  = 8'he1;
    localparam logic [7:0] ALUOP_LWL = 8'he2;
    localparam logic [7:0] ALUOP_LW  = 8'he3;
    localparam logic [7:0] ALUOP_LBU = 8'he4;
    localparam logic [7:0] ALUOP_LHU = 8'he5;
    localparam logic [7:0] ALUOP_LWR = 8'he6;
    localparam logic [7:0] ALUOP_SB  = 8'he8;
    localparam logic [7:0] ALUOP_SH  = 8'he9;
    localparam logic [7:0] ALUOP_SWL = 8'hea;
    localparam logic [7:0] ALUOP_SW  = 8'heb;
    localparam logic [7:0] ALUOP_SWR = 8'hee;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic        clk;
    logic        rst;
    logic        mem_en_i;
    logic        mem_wen_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        flush_i;
    logic        pipe_stall_i;
    logic [31:0] mem_rdata_o;
    logic        mem_stall_o;
    logic [1:0]  dbg_state_o;

    data_sram_ctrl_if bus_if ();

    data_sram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en_i     (mem_en_i),
        .mem_wen_i    (mem_wen_i),
        .aluop_i      (aluop_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .flush_i      (flush_i),
        .pipe_stall_i (pipe_stall_i),
        .bus          (bus_if),
        .mem_rdata_o  (mem_rdata_o),
        .mem_stall_o  (mem_stall_o),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock and scoreboard state
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference bus fields derived from the load/store rules with plain arithmetic.
    function automatic void model_bus(input logic [7:0] op, input logic [31:0] addr,
                                      input logic [31:0] wd, output logic [1:0] size,
                                      output logic [31:0] eaddr, output logic [3:0] strb,
                                      output logic [31:0] ewd, output logic is_st);
        int a;
        int s;
        a     = int'(addr[1:0]);
        size  = 2'd2;
        eaddr = addr;
        s     = 0;
        ewd   = 32'd0;
        is_st = 1'b0;
        case (op)
            ALUOP_LB, ALUOP_LBU: size = 2'd0;
            ALUOP_LH, ALUOP_LHU: size = 2'd1;
            ALUOP_LWL, ALUOP_LWR: eaddr = addr - 32'(a);
            ALUOP_SB: begin size = 2'd0; s = 1 << a; ewd = {24'd0, wd[7:0]} * 32'h01010101; end
            ALUOP_SH: begin size = 2'd1; s = (a >= 2) ? 12 : 3; ewd = {16'd0, wd[15:0]} * 32'h00010001; end
            ALUOP_SW: begin s = 15; ewd = wd; end
            ALUOP_SWL: begin eaddr = addr - 32'(a); s = (1 << (a + 1)) - 1; ewd = wd >> (8 * (3 - a)); end
            ALUOP_SWR: begin eaddr = addr - 32'(a); s = (15 << a) & 15; ewd = wd << (8 * a); end
            default: ;
        endcase
        is_st = (op == ALUOP_SB) || (op == ALUOP_SH) || (op == ALUOP_SW) ||
                (op == ALUOP_SWL) || (op == ALUOP_SWR);
        strb  = s[3:0];
    endfunction

    task automatic drive_idle();
        mem_en_i = 1'b0; mem_wen_i = 1'b0; aluop_i = 8'd0; mem_addr_i = 32'd0;
        mem_wdata_i = 32'd0; flush_i = 1'b0; pipe_stall_i = 1'b0;
        bus_if.data_addr_ok_i = 1'b0; bus_if.data_data_ok_i = 1'b0;
        bus_if.data_rdata_i = $urandom;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_state"}, 32'(dbg_state_o), 32'(ST_IDLE));
        check_val({tag, "_req"},   32'(bus_if.data_req_o), 32'd0);
        check_val({tag, "_stall"}, 32'(mem_stall_o), 32'd0);
        check_val({tag, "_rdata"}, mem_rdata_o, model_rdata);
    endtask

    // One transaction. aw: REQ cycles before addr_ok; dw: cycles from addr_ok to
    // data_ok; fl: cycle index of a flush (-1 none); nxt_en: mem_en after that
    // flush; ps: pipe_stall cycles in DONE; fd: flush in the first DONE cycle.
    task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int aw, input int dw, input int fl,
                           input logic nxt_en, input int ps, input logic fd);
        logic [1:0]  e_size;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        logic        is_st;
        int          dc;
        int          last;
        logic        flushed;
        logic [1:0]  e_state;
        logic        e_stall;
        model_bus(op, addr, wd, e_size, e_addr, e_strb, e_wd, is_st);
        dc      = 1 + aw + dw;
        flushed = (fl >= 1);
        last    = flushed ? dc : (fd ? dc + 1 : dc + 1 + ps);
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            mem_wen_i   = is_st;
            aluop_i     = op;
            mem_addr_i  = addr;
            mem_wdata_i = wd;
            mem_en_i    = (flushed && c > fl) ? nxt_en : 1'b1;
            flush_i     = (flushed && c == fl) || (fd && c == dc + 1);
            pipe_stall_i = (c > dc) && (fd || c <= dc + ps);
            bus_if.data_addr_ok_i = (c == 1 + aw);
            bus_if.data_data_ok_i = (c == dc);
            bus_if.data_rdata_i   = (c == dc) ? rd : $urandom;
            if (c == dc && !flushed && !is_st) exp_q.push_back(rd);
            @(negedge clk);
            if (c == dc + 1 && exp_q.size() != 0) model_rdata = exp_q.pop_front();
            if (c == 0)            e_state = ST_IDLE;
            else if (c <= 1 + aw)  e_state = ST_REQ;
            else if (c <= dc)      e_state = ST_WAIT;
            else                   e_state = ST_DONE;
            e_stall = (c <= dc) && (!flushed || c <= fl || nxt_en);
            check_val("state", 32'(dbg_state_o), 32'(e_state));
            check_val("stall", 32'(mem_stall_o), 32'(e_stall));
            check_val("req", 32'(bus_if.data_req_o), 32'(c >= 1 && c <= 1 + aw));
            check_val("rdata", mem_rdata_o, model_rdata);
            if (c >= 1 && c <= 1 + aw) begin
                check_val("wr",    32'(bus_if.data_wr_o), 32'(is_st));
                check_val("size",  32'(bus_if.data_size_o), 32'(e_size));
                check_val("addr",  bus_if.data_addr_o, e_addr);
                check_val("wstrb", 32'(bus_if.data_wstrb_o), 32'(e_strb));
                if (is_st) check_val("wdata", bus_if.data_wdata_o, e_wd);
            end
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check_quiet("post");
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_en_i = 1'b1;
        aluop_i  = ALUOP_LW;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_val("rst_stall", 32'(mem_stall_o), 32'd0);
            if (i >= 1) begin
                check_val("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
                check_val("rst_req",   32'(bus_if.data_req_o), 32'd0);
                check_val("rst_wr",    32'(bus_if.data_wr_o), 32'd0);
                check_val("rst_size",  32'(bus_if.data_size_o), 32'd0);
                check_val("rst_wstrb", 32'(bus_if.data_wstrb_o), 32'd0);
                check_val("rst_addr",  bus_if.data_addr_o, 32'd0);
                check_val("rst_wdata", bus_if.data_wdata_o, 32'd0);
                check_val("rst_rdata", mem_rdata_o, 32'd0);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        drive_idle();
        model_rdata = 32'd0;
        exp_q.delete();
    endtask

    // Stimulus and final report
    initial begin
        logic [7:0] ops [12];
        logic [7:0] op;
        logic [31:0] addr;
        int aw, dw, dc, fl, ps;
        ops = '{ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW, ALUOP_LWL,
                ALUOP_LWR, ALUOP_SB, ALUOP_SH, ALUOP_SW, ALUOP_SWL, ALUOP_SWR};
        rst = 1'b1;
        drive_idle();
        model_rdata = 32'd0;
        apply_reset(3);

        // Fastest load, delayed-accept byte store, partial-word stores.
        run_txn(ALUOP_LW,  32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, -1, 1'b0, 0, 1'b0);
        run_txn(ALUOP_SB,  32'h1003, 32'h000000A5, 32'h0, 3, 1, -1, 1'b0, 0, 1'b0);
        run_txn(ALUOP_SWR, 32'h2001, 32'h11223344, 32'h0, 0, 0, -1, 1'b0, 0, 1'b0);
        run_txn(ALUOP_SWL, 32'h2001, 32'h11223344, 32'h0, 1, 0, -1, 1'b0, 0, 1'b0);
        // Flush while waiting for data: the result must not be captured.
        run_txn(ALUOP_LW,  32'h3000, 32'h0, 32'hCAFEF00D, 0, 3, 2, 1'b0, 0, 1'b0);
        // Held in DONE by another stall source, then flushed out of DONE.
        run_txn(ALUOP_LH,  32'h4002, 32'h0, 32'h55AA1234, 1, 1, -1, 1'b0, 3, 1'b0);
        run_txn(ALUOP_LBU, 32'h4003, 32'h0, 32'h0BADC0DE, 0, 1, -1, 1'b0, 0, 1'b1);
        // Dropped transaction with a newer memory instruction waiting behind it.
        run_txn(ALUOP_LB,  32'h5001, 32'h0, 32'h77777777, 2, 2, 1, 1'b1, 0, 1'b0);

        // Flush in IDLE blocks issue.
        @(posedge clk); #1;
        mem_en_i = 1'b1; aluop_i = ALUOP_LW; mem_addr_i = 32'h6000; flush_i = 1'b1;
        @(negedge clk);
        check_val("idle_flush_stall", 32'(mem_stall_o), 32'd0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check_quiet("idle_flush");

        // Reset in WAIT abandons the transaction.
        @(posedge clk); #1;
        mem_en_i = 1'b1; aluop_i = ALUOP_LW; mem_addr_i = 32'h7000;
        @(posedge clk); #1;
        bus_if.data_addr_ok_i = 1'b1;
        @(posedge clk); #1;
        bus_if.data_addr_ok_i = 1'b0;
        @(negedge clk);
        check_val("pre_rst_state", 32'(dbg_state_o), 32'(ST_WAIT));
        apply_reset(2);

        // Randomized transactions.
        for (int n = 0; n < 200; n++) begin
            op   = ops[$urandom_range(0, 11)];
            addr = $urandom;
            if (op == ALUOP_LH || op == ALUOP_LHU || op == ALUOP_SH) addr[0] = 1'b0;
            if (op == ALUOP_LW || op == ALUOP_SW) addr[1:0] = 2'b00;
            aw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            dc = 1 + aw + dw;
            fl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, dc) : -1;
            ps = $urandom_range(0, 3);
            run_txn(op, addr, $urandom, $urandom, aw, dw, fl, 1'($urandom_range(0, 1)), ps,
                    (fl < 0) && ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
